// File: rtl/l1_strm_ptr_ctrl.sv
// Per-stream L1 read-pointer controller: advances each stream's read pointer by
// the number of accepted port requests, tracks valid lines held in L1, returns
// a free credit per fully read line and flags end-of-stream / single-line state.
module l1_strm_ptr_ctrl #(
  parameter int nstrms       = 64,
  parameter int nstrms_width = $clog2(nstrms),
  parameter int nports       = 8,
  parameter int cl_size      = 8,
  parameter int clofs_width  = $clog2(cl_size),
  parameter int nlines       = 4,
  parameter int ptr_width    = $clog2(nlines) + clofs_width
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_start_v,
  input  logic [nstrms_width-1:0]       i_start_sid,
  input  logic                          i_clr_v,
  input  logic [nstrms_width-1:0]       i_clr_sid,
  input  logic                          i_fill_v,
  output logic                          i_fill_r,
  input  logic [nstrms_width-1:0]       i_fill_sid,
  input  logic [nstrms-1:0]             i_rst_end,
  input  logic [nports*nstrms-1:0]      i_req_v,
  output logic [nports*nstrms-1:0]      i_req_r,
  output logic [nstrms*ptr_width-1:0]   o_ptrs,
  output logic [nstrms-1:0]             o_l1_end,
  output logic [nstrms-1:0]             o_single_v,
  output logic [nstrms-1:0]             o_free_v
);

  localparam int ncl_width = $clog2(nlines + 1);
  localparam int inc_width = clofs_width + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_END
  } strm_state_e;

  strm_state_e            state_q [nstrms];
  strm_state_e            state_d [nstrms];
  logic [ptr_width-1:0]   ptr_q   [nstrms];
  logic [ptr_width-1:0]   ptr_d   [nstrms];
  logic [ncl_width-1:0]   ncl_q   [nstrms];
  logic [ncl_width-1:0]   ncl_d   [nstrms];
  logic [nstrms-1:0]      rdy;
  logic [nstrms-1:0]      free_d;
  logic [nstrms-1:0]      single_d;
  logic [nstrms-1:0]      end_d;

  // Ready terms: a stream accepts reads only while active with a valid line.
  always_comb begin
    rdy      = '0;
    i_req_r  = '0;
    for (int unsigned s = 0; s < nstrms; s++) begin
      rdy[s] = (state_q[s] == ST_ACTIVE) && (ncl_q[s] != '0);
    end
    for (int unsigned p = 0; p < nports; p++) begin
      for (int unsigned s = 0; s < nstrms; s++) begin
        i_req_r[p*nstrms + s] = rdy[s];
      end
    end
    i_fill_r = (state_q[i_fill_sid] == ST_ACTIVE) &&
               (ncl_q[i_fill_sid] != ncl_width'(nlines));
  end

  // Per-stream next state: pointer advance, line accounting, FSM transitions.
  always_comb begin
    logic [inc_width-1:0]   inc;
    logic [clofs_width:0]   sum;
    logic                   carry;
    logic                   fill;
    inc      = '0;
    sum      = '0;
    carry    = 1'b0;
    fill     = 1'b0;
    free_d   = '0;
    single_d = '0;
    end_d    = '0;
    for (int unsigned s = 0; s < nstrms; s++) begin
      inc = '0;
      for (int unsigned p = 0; p < nports; p++) begin
        inc = inc + inc_width'(i_req_v[p*nstrms + s] & rdy[s]);
      end
      // A carry out of the line-offset bits means the current line is fully read.
      sum   = {1'b0, ptr_q[s][clofs_width-1:0]} + inc;
      carry = sum[clofs_width];
      fill  = i_fill_v && i_fill_r && (i_fill_sid == nstrms_width'(s));

      state_d[s] = state_q[s];
      ptr_d[s]   = ptr_q[s] + ptr_width'(inc);
      ncl_d[s]   = ncl_q[s] + ncl_width'(fill) - ncl_width'(carry);
      free_d[s]  = carry;

      case (state_q[s])
        ST_IDLE: begin
          if (i_start_v && (i_start_sid == nstrms_width'(s))) begin
            state_d[s] = ST_ACTIVE;
            ptr_d[s]   = '0;
            ncl_d[s]   = '0;
          end
        end
        ST_ACTIVE: begin
          if (i_rst_end[s] && (ncl_d[s] == '0)) begin
            state_d[s] = ST_END;
          end
        end
        default: ;
      endcase

      // Clear overrides every other event on the stream, including the free credit.
      if (i_clr_v && (i_clr_sid == nstrms_width'(s))) begin
        state_d[s] = ST_IDLE;
        ptr_d[s]   = '0;
        ncl_d[s]   = '0;
        free_d[s]  = 1'b0;
      end

      single_d[s] = (state_d[s] == ST_ACTIVE) && (ncl_d[s] == ncl_width'(1));
      end_d[s]    = (state_d[s] == ST_END);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < nstrms; s++) begin
        state_q[s] <= ST_IDLE;
        ptr_q[s]   <= '0;
        ncl_q[s]   <= '0;
      end
      o_free_v   <= '0;
      o_single_v <= '0;
      o_l1_end   <= '0;
    end else begin
      for (int unsigned s = 0; s < nstrms; s++) begin
        state_q[s] <= state_d[s];
        ptr_q[s]   <= ptr_d[s];
        ncl_q[s]   <= ncl_d[s];
      end
      o_free_v   <= free_d;
      o_single_v <= single_d;
      o_l1_end   <= end_d;
    end
  end

  // Flatten the pointer array onto the output bus.
  always_comb begin
    o_ptrs = '0;
    for (int unsigned s = 0; s < nstrms; s++) begin
      o_ptrs[s*ptr_width +: ptr_width] = ptr_q[s];
    end
  end

endmodule

// File: tb/tb_l1_strm_ptr_ctrl.sv
// Scoreboarded random + directed bench for l1_strm_ptr_ctrl.
module tb_l1_strm_ptr_ctrl;

  localparam int NS = 64;
  localparam int SW = 6;
  localparam int NP = 8;
  localparam int CL = 8;
  localparam int NL = 4;
  localparam int PW = 5;

  logic               clk;
  logic               reset;
  logic               i_start_v;
  logic [SW-1:0]      i_start_sid;
  logic               i_clr_v;
  logic [SW-1:0]      i_clr_sid;
  logic               i_fill_v;
  logic               i_fill_r;
  logic [SW-1:0]      i_fill_sid;
  logic [NS-1:0]      i_rst_end;
  logic [NP*NS-1:0]   i_req_v;
  logic [NP*NS-1:0]   i_req_r;
  logic [NS*PW-1:0]   o_ptrs;
  logic [NS-1:0]      o_l1_end;
  logic [NS-1:0]      o_single_v;
  logic [NS-1:0]      o_free_v;

  l1_strm_ptr_ctrl #(
    .nstrms  (NS),
    .nports  (NP),
    .cl_size (CL),
    .nlines  (NL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_start_v   (i_start_v),
    .i_start_sid (i_start_sid),
    .i_clr_v     (i_clr_v),
    .i_clr_sid   (i_clr_sid),
    .i_fill_v    (i_fill_v),
    .i_fill_r    (i_fill_r),
    .i_fill_sid  (i_fill_sid),
    .i_rst_end   (i_rst_end),
    .i_req_v     (i_req_v),
    .i_req_r     (i_req_r),
    .o_ptrs      (o_ptrs),
    .o_l1_end    (o_l1_end),
    .o_single_v  (o_single_v),
    .o_free_v    (o_free_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NS*PW-1:0] ptrs;
    logic [NS-1:0]    l1e;
    logic [NS-1:0]    single;
    logic [NS-1:0]    free;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 active, 2 ended; rd counts total reads since start.
  int          mst [NS];
  int unsigned rd  [NS];
  int          ncl [NS];
  int          hot [5] = '{1, 2, 3, 5, 7};

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      mst[s] = 0;
      rd[s]  = 0;
      ncl[s] = 0;
    end
    exp_q.delete();
  endtask

  // Called right after a falling edge with inputs set: checks ready outputs,
  // advances the model over the coming rising edge and queues the expected view.
  task automatic tick();
    logic [NP*NS-1:0] exp_rr;
    logic             exp_fr;
    exp_t             e;
    int               acc;
    bit               fl;
    bit               freed;
    int unsigned      nrd;
    int               nncl;
    #1;
    exp_rr = '0;
    for (int s = 0; s < NS; s++)
      for (int p = 0; p < NP; p++)
        exp_rr[p*NS + s] = (mst[s] == 1) && (ncl[s] > 0);
    exp_fr = (mst[i_fill_sid] == 1) && (ncl[i_fill_sid] < NL);
    chk("req_r", i_req_r, exp_rr);
    chk("fill_r", i_fill_r, exp_fr);
    for (int s = 0; s < NS; s++) begin
      acc = 0;
      for (int p = 0; p < NP; p++)
        if (exp_rr[p*NS + s] && i_req_v[p*NS + s]) acc++;
      fl    = i_fill_v && exp_fr && (int'(i_fill_sid) == s);
      nrd   = rd[s] + acc;
      freed = (nrd / CL) != (rd[s] / CL);
      nncl  = ncl[s] + int'(fl) - int'(freed);
      if (i_clr_v && int'(i_clr_sid) == s) begin
        mst[s] = 0; rd[s] = 0; ncl[s] = 0; freed = 0;
      end else if (mst[s] == 0) begin
        if (i_start_v && int'(i_start_sid) == s) begin
          mst[s] = 1; rd[s] = 0; ncl[s] = 0;
        end
      end else if (mst[s] == 1) begin
        rd[s]  = nrd;
        ncl[s] = nncl;
        if (i_rst_end[s] && nncl == 0) mst[s] = 2;
      end
      e.ptrs[s*PW +: PW] = PW'(rd[s] % (NL * CL));
      e.free[s]          = freed;
      e.single[s]        = (mst[s] == 1) && (ncl[s] == 1);
      e.l1e[s]           = (mst[s] == 2);
    end
    exp_q.push_back(e);
    @(negedge clk);
    i_start_v = 1'b0;
    i_clr_v   = 1'b0;
    i_fill_v  = 1'b0;
    i_req_v   = '0;
  endtask

  task automatic t_start(input int s);
    i_start_v = 1'b1; i_start_sid = SW'(s); tick();
  endtask

  task automatic t_fill(input int s);
    i_fill_v = 1'b1; i_fill_sid = SW'(s); tick();
  endtask

  task automatic t_read(input int s, input int nports_on);
    for (int p = 0; p < nports_on; p++) i_req_v[p*NS + s] = 1'b1;
    tick();
  endtask

  // Asserts reset between edges and checks every output clears at once.
  task automatic mid_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_ptrs", o_ptrs, '0);
    chk("rst_l1_end", o_l1_end, '0);
    chk("rst_single", o_single_v, '0);
    chk("rst_free", o_free_v, '0);
    chk("rst_req_r", i_req_r, '0);
    chk("rst_fill_r", i_fill_r, '0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic int pick();
    if ($urandom_range(0, 3) != 0) return hot[$urandom_range(0, 4)];
    return int'($urandom_range(0, NS - 1));
  endfunction

  task automatic rand_tick();
    int s;
    if ($urandom_range(0, 3) == 0) begin i_start_v = 1'b1; i_start_sid = SW'(pick()); end
    if ($urandom_range(0, 29) == 0) begin i_clr_v = 1'b1; i_clr_sid = SW'(pick()); end
    if ($urandom_range(0, 1) == 1) begin i_fill_v = 1'b1; i_fill_sid = SW'(pick()); end
    if ($urandom_range(0, 15) == 0) begin s = pick(); i_rst_end[s] = ~i_rst_end[s]; end
    for (int p = 0; p < NP; p++)
      for (int h = 0; h < 5; h++)
        if ($urandom_range(0, 2) == 0) i_req_v[p*NS + hot[h]] = 1'b1;
    i_req_v[$urandom_range(0, NP*NS - 1)] = 1'b1;
    tick();
  endtask

  // Monitor: compares registered outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ptrs", o_ptrs, e.ptrs);
        chk("free_v", o_free_v, e.free);
        chk("single_v", o_single_v, e.single);
        chk("l1_end", o_l1_end, e.l1e);
      end
    end
  end

  initial begin
    logic [NP-1:0] rdy7;
    reset = 1'b0;
    i_start_v = 1'b0; i_start_sid = '0;
    i_clr_v = 1'b0;   i_clr_sid = '0;
    i_fill_v = 1'b0;  i_fill_sid = '0;
    i_rst_end = '0;   i_req_v = '0;
    model_reset();
    #3;
    chk("rst_ptrs", o_ptrs, '0);
    chk("rst_l1_end", o_l1_end, '0);
    chk("rst_single", o_single_v, '0);
    chk("rst_free", o_free_v, '0);
    chk("rst_req_r", i_req_r, '0);
    chk("rst_fill_r", i_fill_r, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Start and simple reads on stream 3.
    t_start(3);
    t_fill(3);
    for (int i = 0; i < 8; i++) t_read(3, 1);
    chk("s3_ptr", o_ptrs[3*PW +: PW], PW'(8));
    chk("s3_free", o_free_v[3], 1'b1);
    chk("s3_rdy", i_req_r[3], 1'b0);

    // Multi-port carry on stream 5.
    t_start(5);
    t_fill(5);
    t_fill(5);
    for (int i = 0; i < 6; i++) t_read(5, 1);
    t_read(5, 4);
    chk("s5_ptr", o_ptrs[5*PW +: PW], PW'(10));
    chk("s5_free", o_free_v[5], 1'b1);
    chk("s5_single", o_single_v[5], 1'b1);

    // Fill against a full stream while a line frees, then a refill.
    t_start(1);
    for (int i = 0; i < 4; i++) t_fill(1);
    for (int i = 0; i < 7; i++) t_read(1, 1);
    i_fill_v = 1'b1; i_fill_sid = SW'(1); i_req_v[1] = 1'b1;
    tick();
    t_fill(1);
    t_fill(1);

    // End detection on stream 2.
    t_start(2);
    t_fill(2);
    i_rst_end[2] = 1'b1;
    for (int i = 0; i < 8; i++) t_read(2, 1);
    chk("s2_end", o_l1_end[2], 1'b1);
    chk("s2_rdy", i_req_r[2], 1'b0);

    // Pointer wrap on stream 6: keep filling while reading every cycle.
    t_start(6);
    for (int i = 0; i < 40; i++) begin
      i_fill_v = 1'b1; i_fill_sid = SW'(6); i_req_v[6] = 1'b1;
      tick();
    end

    // Clear stream 7 with a carrying request pending.
    t_start(7);
    for (int i = 0; i < 3; i++) t_fill(7);
    for (int i = 0; i < 7; i++) t_read(7, 1);
    i_clr_v = 1'b1; i_clr_sid = SW'(7);
    i_fill_v = 1'b1; i_fill_sid = SW'(7);
    t_read(7, 3);
    chk("s7_free", o_free_v[7], 1'b0);
    chk("s7_ptr", o_ptrs[7*PW +: PW], '0);
    for (int p = 0; p < NP; p++) rdy7[p] = i_req_r[p*NS + 7];
    chk("s7_rdy", rdy7, '0);
    mid_reset();

    // Randomized traffic with a reset landing mid-operation.
    for (int i = 0; i < 1500; i++) rand_tick();
    mid_reset();
    i_rst_end = '0;
    for (int i = 0; i < 1500; i++) rand_tick();
    mid_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
